uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side companion to the UART transmit controller. Takes byte-valid pulses from the UART receiver, discards bytes flagged with framing errors, and pushes good bytes into the RX FIFO. One byte is held while the FIFO is full; further bytes are dropped and counted. An idle-line timeout produces a frame-end pulse that downstream logic (I2C command path) uses as a packet delimiter.

## Interface
- UART_FIFO_WIDTH, 8, FIFO write-data width; must be >= UART_DATA_WIDTH, with the byte zero-extended into the LSBs
- UART_DATA_WIDTH, 8, UART byte width
- CNT_WIDTH, 8, width of the drop and error counters
- IDLE_TIMEOUT, 1024, clocks of silence after the last accepted byte before frame_end; minimum 2
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  synchronous, active-low reset
- uart_rx_dv  input  1  one-cycle pulse: uart_rx_data is valid
- uart_rx_data  input  UART_DATA_WIDTH  received byte
- uart_rx_frame_err  input  1  qualifies uart_rx_dv; 1 means bad stop bit and the byte is discarded
- f_full  input  1  RX FIFO full
- fifo_write_en  output  1  one-cycle FIFO write strobe
- fifo_write_data  output  UART_FIFO_WIDTH  FIFO write data; 0 when fifo_write_en is 0
- clear_status  input  1  one-cycle pulse that clears overflow, drop_count and err_count
- overflow  output  1  sticky: at least one good byte was dropped
- drop_count  output  CNT_WIDTH  good bytes dropped, saturating
- err_count  output  CNT_WIDTH  framing-error bytes, saturating
- frame_end  output  1  one-cycle pulse marking the end of a received burst

## Operation
- **Accepted byte:** uart_rx_dv=1 and uart_rx_frame_err=0.
- **Error byte:** uart_rx_dv=1 and uart_rx_frame_err=1. It is never written, in any state. err_count increments (saturating at all-ones). The idle timer is not touched.
- **IDLE**
  - Accepted byte and f_full=0: latch it to the output register, go to WRITE.
  - Accepted byte and f_full=1: latch it to the hold register, go to STALL.
- **WRITE**
  - fifo_write_en=1 for exactly this cycle.
  - f_full is considered stale in this cycle. An accepted byte here goes to the hold register and the FSM goes to STALL (full is re-checked there).
  - Otherwise go to IDLE.
- **STALL**
  - If f_full=0: move the held byte to the output register and go to WRITE.
  - Any accepted byte in STALL is dropped, including when f_full=0 in the same cycle. A drop sets overflow and increments drop_count (saturating).
- **Idle timer**
  - An accepted byte arms the timer and zeroes the count.
  - While armed, the count increments every cycle with no accepted byte.
  - On reaching IDLE_TIMEOUT-1 the count saturates.
  - frame_end pulses on the first cycle that the saturated condition holds and the state is IDLE. That pulse disarms the timer.
  - Not armed means no frame_end, ever.
- **clear_status:** zeroes overflow, drop_count and err_count. If a drop or error event occurs in the same cycle, the event wins over the clear: the affected counter becomes 1 and/or overflow becomes 1.

## Timing
- **Reset** (rst_n=0 at a clock edge): all outputs 0, state IDLE, hold register cleared, timer disarmed.
  - A byte held or in flight is discarded.
  - uart_rx_dv during reset is ignored.
- **Latency:** an accepted byte sampled at edge N with f_full=0 in IDLE gives fifo_write_en=1 and fifo_write_data=byte in cycle N+1.
- **Stall release:** f_full sampled 0 at edge M in STALL gives the write in cycle M+1.
- **Writes:** never back-to-back; there is at least one cycle of fifo_write_en=0 between writes.
- **frame_end:** for a lone accepted byte sampled at edge N, frame_end is high in cycle N+IDLE_TIMEOUT, provided there is no stall.
- **Outputs:** all are registered, with no combinational input-to-output path.

## Test plan
- **Simple write.** After reset, dv with data 0xA5, f_full=0 → fifo_write_en for 1 cycle with data 0x00A5 one cycle later; drop_count=0, err_count=0.
- **Framing error.** dv with data 0x3C and frame_err=1 → no write, err_count=1, no frame_end ever. Repeat 300 times with CNT_WIDTH=8 → err_count saturates at 255.
- **Full FIFO, hold and drop.** f_full=1, then dv 0x11 → no write. A second dv 0x22 → overflow=1, drop_count=1. Release f_full → exactly one write of 0x11; 0x22 is never written.
- **Frame end.** IDLE_TIMEOUT=16, bytes 0x01, 0x02 five cycles apart → frame_end exactly once, 16 cycles after the 0x02 dv. A new byte afterwards → a second frame_end 16 cycles later.
- **Clear versus event.** overflow=1 and drop_count=3; clear_status in the same cycle as a drop → drop_count=1, overflow=1. clear_status alone → all three status outputs 0.
- **Reset mid-operation.** A byte held in STALL, rst_n low for 1 cycle, then f_full released → no write, all outputs 0, no frame_end.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side byte handler sitting between the UART receiver and the RX
//   FIFO. Good bytes are written to the FIFO one at a time, with a single
//   byte of holding while the FIFO is full. Bytes arriving while a byte is
//   already held are dropped and counted. Bytes with a framing error are
//   never written and only counted. An idle timer after the last good byte
//   produces a one-cycle frame_end pulse that marks the end of a burst.
//
// Ports
//   clk, rst_n         system clock, synchronous active-low reset
//   uart_rx_dv         one-cycle byte-valid pulse from the receiver
//   uart_rx_data       received byte
//   uart_rx_frame_err  byte had a bad stop bit (qualifies uart_rx_dv)
//   f_full             RX FIFO full
//   fifo_write_en      one-cycle FIFO write strobe
//   fifo_write_data    zero-extended byte, 0 when no write
//   clear_status       clears overflow / drop_count / err_count
//   overflow           sticky: a good byte was dropped
//   drop_count         dropped good bytes, saturating
//   err_count          framing-error bytes, saturating
//   frame_end          one-cycle end-of-burst pulse
module uart_rx_ctrl #(
    parameter int UART_FIFO_WIDTH = 8,
    parameter int UART_DATA_WIDTH = 8,
    parameter int CNT_WIDTH       = 8,
    parameter int IDLE_TIMEOUT    = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_rx_dv,
    input  logic [UART_DATA_WIDTH-1:0] uart_rx_data,
    input  logic                       uart_rx_frame_err,
    input  logic                       f_full,
    output logic                       fifo_write_en,
    output logic [UART_FIFO_WIDTH-1:0] fifo_write_data,
    input  logic                       clear_status,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_count,
    output logic [CNT_WIDTH-1:0]       err_count,
    output logic                       frame_end
);

    localparam int TW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_STALL} state_t;

    state_t                     state, state_nx;
    logic [UART_DATA_WIDTH-1:0] hold_q;
    logic                       accept, err_byte;
    logic                       load_out, out_from_hold, load_hold, drop;
    logic [UART_DATA_WIDTH-1:0] out_byte;
    logic [UART_FIFO_WIDTH-1:0] out_ext;
    logic                       tmr_armed;
    logic [TW-1:0]              tmr_cnt;
    logic                       fire;

    assign accept   = uart_rx_dv & ~uart_rx_frame_err;
    assign err_byte = uart_rx_dv &  uart_rx_frame_err;

    always_comb begin
        state_nx      = state;
        load_out      = 1'b0;
        out_from_hold = 1'b0;
        load_hold     = 1'b0;
        drop          = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (f_full) begin
                        load_hold = 1'b1;
                        state_nx  = S_STALL;
                    end else begin
                        load_out = 1'b1;
                        state_nx = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // f_full may not yet reflect the write going out this cycle,
                // so a new byte is parked and full is re-checked in STALL.
                if (accept) begin
                    load_hold = 1'b1;
                    state_nx  = S_STALL;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_STALL: begin
                // The hold slot is occupied for this whole cycle, so a new
                // byte is lost even if the held one is released now.
                drop = accept;
                if (!f_full) begin
                    load_out      = 1'b1;
                    out_from_hold = 1'b1;
                    state_nx      = S_WRITE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        out_byte = out_from_hold ? hold_q : uart_rx_data;
        out_ext  = '0;
        out_ext[UART_DATA_WIDTH-1:0] = out_byte;
    end

    // Timer only counts toward frame_end in IDLE; a stall keeps it parked
    // at T_MAX until the FSM drains back to IDLE.
    assign fire = tmr_armed && (tmr_cnt == T_MAX) && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            hold_q          <= '0;
            fifo_write_en   <= 1'b0;
            fifo_write_data <= '0;
            overflow        <= 1'b0;
            drop_count      <= '0;
            err_count       <= '0;
            frame_end       <= 1'b0;
            tmr_armed       <= 1'b0;
            tmr_cnt         <= '0;
        end else begin
            state           <= state_nx;
            fifo_write_en   <= load_out;
            fifo_write_data <= load_out ? out_ext : '0;
            if (load_hold)
                hold_q <= uart_rx_data;

            // An event in the same cycle as clear_status wins: the counter
            // restarts at 1 rather than 0.
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clear_status ? CNT_WIDTH'(1) :
                              (&drop_count) ? drop_count : drop_count + 1'b1;
            end else if (clear_status) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end

            if (err_byte)
                err_count <= clear_status ? CNT_WIDTH'(1) :
                             (&err_count) ? err_count : err_count + 1'b1;
            else if (clear_status)
                err_count <= '0;

            frame_end <= fire;
            if (accept) begin
                tmr_armed <= 1'b1;
                tmr_cnt   <= '0;
            end else if (fire) begin
                tmr_armed <= 1'b0;
            end else if (tmr_armed && tmr_cnt != T_MAX) begin
                tmr_cnt <= tmr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized + directed bench for uart_rx_ctrl. A transaction-level model
// predicts FIFO writes, frame_end pulses and status values; a monitor pops
// the predictions as the DUT produces outputs.
module tb_uart_rx_ctrl;

    localparam int FW = 16;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_rx_dv = 1'b0;
    logic [DW-1:0] uart_rx_data = '0;
    logic          uart_rx_frame_err = 1'b0;
    logic          f_full = 1'b0;
    logic          fifo_write_en;
    logic [FW-1:0] fifo_write_data;
    logic          clear_status = 1'b0;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] err_count;
    logic          frame_end;

    uart_rx_ctrl #(
        .UART_FIFO_WIDTH(FW), .UART_DATA_WIDTH(DW),
        .CNT_WIDTH(CW), .IDLE_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .uart_rx_dv(uart_rx_dv), .uart_rx_data(uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err), .f_full(f_full),
        .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
        .clear_status(clear_status), .overflow(overflow),
        .drop_count(drop_count), .err_count(err_count),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [FW-1:0] data; } wr_t;
    wr_t wq[$];
    int  fq[$];

    int total = 0;
    int bad   = 0;

    // model state
    bit            chk_en  = 0;
    bit            m_hold_v = 0;
    logic [DW-1:0] m_hold  = '0;
    bit            m_writing = 0;
    bit            m_armed = 0;
    int            m_last  = 0;
    bit            m_ov    = 0;
    logic [CW-1:0] m_drop  = '0;
    logic [CW-1:0] m_err   = '0;

    // Predict the effect of the upcoming rising edge given the driven inputs.
    task automatic model_edge();
        int  e;
        bit  acc, errb, fe, nw, dropped;
        wr_t w;
        e = cyc + 1;
        if (!rst_n) begin
            chk_en = 1; m_hold_v = 0; m_writing = 0; m_armed = 0;
            m_ov = 0; m_drop = '0; m_err = '0;
            return;
        end
        acc  = uart_rx_dv && !uart_rx_frame_err;
        errb = uart_rx_dv &&  uart_rx_frame_err;
        fe = m_armed && (e - m_last >= T) && !m_hold_v && !m_writing;
        if (fe) fq.push_back(e);
        nw = 0; dropped = 0;
        if (m_hold_v) begin
            if (acc) dropped = 1;
            if (!f_full) begin
                w.cyc = e; w.data = FW'(m_hold); wq.push_back(w);
                m_hold_v = 0; nw = 1;
            end
        end else if (acc) begin
            if (m_writing || f_full) begin
                m_hold_v = 1; m_hold = uart_rx_data;
            end else begin
                w.cyc = e; w.data = FW'(uart_rx_data); wq.push_back(w);
                nw = 1;
            end
        end
        m_writing = nw;
        if (acc) begin
            m_armed = 1; m_last = e;
        end else if (fe) begin
            m_armed = 0;
        end
        if (clear_status) begin
            m_ov = 0; m_drop = '0; m_err = '0;
        end
        if (dropped) begin
            m_ov = 1;
            if (m_drop != '1) m_drop = m_drop + 1'b1;
        end
        if (errb && m_err != '1) m_err = m_err + 1'b1;
    endtask

    task automatic tick(input logic d, input logic [DW-1:0] b,
                        input logic fe, input logic c);
        uart_rx_dv = d; uart_rx_data = b; uart_rx_frame_err = fe;
        clear_status = c;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        uart_rx_dv = 1'b0; clear_status = 1'b0; uart_rx_frame_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    // monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                while (wq.size() > 0 && wq[0].cyc < cyc) begin
                    total++; bad++;
                    $display("FAIL missed_write cyc=%0d exp_data=%h exp_cyc=%0d", cyc, wq[0].data, wq[0].cyc);
                    void'(wq.pop_front());
                end
                total++;
                if (fifo_write_en) begin
                    if (wq.size() == 0 || wq[0].cyc != cyc) begin
                        bad++;
                        $display("FAIL unexpected_write cyc=%0d got_data=%h", cyc, fifo_write_data);
                    end else begin
                        if (fifo_write_data !== wq[0].data) begin
                            bad++;
                            $display("FAIL write_data cyc=%0d got=%h exp=%h", cyc, fifo_write_data, wq[0].data);
                        end
                        void'(wq.pop_front());
                    end
                end else if (fifo_write_data !== '0) begin
                    bad++;
                    $display("FAIL idle_data cyc=%0d got=%h exp=0", cyc, fifo_write_data);
                end

                while (fq.size() > 0 && fq[0] < cyc) begin
                    total++; bad++;
                    $display("FAIL missed_frame_end cyc=%0d exp_cyc=%0d", cyc, fq[0]);
                    void'(fq.pop_front());
                end
                total++;
                if (frame_end) begin
                    if (fq.size() == 0 || fq[0] != cyc) begin
                        bad++;
                        $display("FAIL unexpected_frame_end cyc=%0d", cyc);
                    end else begin
                        void'(fq.pop_front());
                    end
                end

                total++;
                if (overflow !== m_ov) begin
                    bad++;
                    $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ov);
                end
                total++;
                if (drop_count !== m_drop) begin
                    bad++;
                    $display("FAIL drop_count cyc=%0d got=%0d exp=%0d", cyc, drop_count, m_drop);
                end
                total++;
                if (err_count !== m_err) begin
                    bad++;
                    $display("FAIL err_count cyc=%0d got=%0d exp=%0d", cyc, err_count, m_err);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        // reset, with a byte pulse that must be ignored
        rst_n = 1'b0;
        tick(1'b1, 8'h77, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // simple write
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(3);

        // framing errors, then saturation of err_count
        tick(1'b1, 8'h3C, 1'b1, 1'b0);
        idle(30);
        for (int i = 0; i < 300; i++) tick(1'b1, 8'h3C, 1'b1, 1'b0);
        idle(3);

        // full FIFO: hold 0x11, drop 0x22, release
        f_full = 1'b1;
        idle(2);
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        idle(2);
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        idle(3);
        f_full = 1'b0;
        idle(30);

        // frame end spacing
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        idle(4);
        tick(1'b1, 8'h02, 1'b0, 1'b0);
        idle(25);
        tick(1'b1, 8'h03, 1'b0, 1'b0);
        idle(25);

        // clear vs event
        tick(1'b0, '0, 1'b0, 1'b1);
        f_full = 1'b1;
        tick(1'b1, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            tick(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
        end
        idle(1);
        tick(1'b1, 8'h50, 1'b0, 1'b1);
        idle(1);
        tick(1'b0, '0, 1'b0, 1'b1);
        idle(2);
        f_full = 1'b0;
        idle(25);

        // reset mid-operation with a byte held
        f_full = 1'b1;
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        idle(2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        f_full = 1'b0;
        idle(30);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic d, fe, c;
            if ($urandom_range(0, 9) == 0) f_full = ~f_full;
            rst_n = ($urandom_range(0, 499) != 0);
            d  = ($urandom_range(0, 9) < 3);
            fe = ($urandom_range(0, 6) == 0);
            c  = ($urandom_range(0, 49) == 0);
            tick(d, 8'($urandom), fe, c);
        end
        rst_n = 1'b1;
        f_full = 1'b0;
        idle(40);

        total++;
        if (wq.size() != 0 || fq.size() != 0) begin
            bad++;
            $display("FAIL queues_drained got_wq=%0d got_fq=%0d exp=0", wq.size(), fq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
